// File: rtl/fpu_cvt_pkg.sv
// fpu_cvt_pkg: shared conversion modes, request record and widths for the
// FP-to-integer conversion sequencer.
package fpu_cvt_pkg;
    localparam int CVT_RES_W  = 65;
    localparam int CVT_DATA_W = 84;
    localparam int CVT_TAG_W  = 9;
    localparam int CVT_OPD_W  = 82;
    typedef enum logic [2:0] {
        CVT_S   = 3'd0,
        CVT_D   = 3'd1,
        CVT_E   = 3'd2,
        CVT32_S = 3'd3,
        CVT32_D = 3'd4,
        TBL_D   = 3'd5
    } cvt_mode_t;
    typedef struct packed {
        cvt_mode_t               mode;
        logic [CVT_DATA_W-1:0]   data;
        logic [CVT_TAG_W-1:0]    tag;
    } cvt_req_t;
    // Modes whose converter operand keeps the 16-bit extension field.
    function automatic logic ext_mode(cvt_mode_t m);
        return m inside {CVT_D, CVT32_D, CVT_E};
    endfunction
endpackage

// File: rtl/cvt_FP_I_mod.sv
// cvt_FP_I_mod: single-register FP (single/double/extended) to 65-bit signed
// integer converter, truncating toward zero and saturating with alt on overflow.
module cvt_FP_I_mod (
    input  logic        clk,
    input  logic        rst,
    input  logic        clkEn,
    input  logic [81:0] A,
    input  logic        isDBL,
    input  logic        isEXT,
    input  logic        isSNG,
    input  logic        is32b,
    input  logic        verbatim,
    output logic [64:0] res,
    output logic        alt
);
    logic               sgn, inf_nan, tiny, ovf, a_d, unused_a;
    logic signed [17:0] e;
    logic [63:0]        m, mag;
    logic [64:0]        sat, r_d;
    assign unused_a = A[65];
    always_comb begin
        sgn     = A[31];
        e       = $signed({10'b0, A[30:23]}) - 18'sd127;
        m       = {1'b1, A[22:0], 40'b0};
        inf_nan = &A[30:23];
        tiny    = ~|A[30:23];
        if (isDBL) begin
            sgn     = A[63];
            e       = $signed({7'b0, A[62:52]}) - 18'sd1023;
            m       = {1'b1, A[51:0], 11'b0};
            inf_nan = &A[62:52];
            tiny    = ~|A[62:52];
        end else if (isEXT) begin
            sgn     = A[81];
            e       = $signed({3'b0, A[80:66]}) - 18'sd16383;
            m       = A[63:0];
            inf_nan = &A[80:66];
            tiny    = ~|A[80:66];
        end
        mag = (tiny || e < 18'sd0 || e > 18'sd63) ? 64'd0 : m >> (6'd63 - e[5:0]);
        ovf = inf_nan || (!tiny && e > 18'sd63) ||
              (is32b && (sgn ? mag > 64'h8000_0000 : mag > 64'h7FFF_FFFF));
        sat = is32b ? (sgn ? {{34{1'b1}}, 31'h0} : {34'h0, {31{1'b1}}})
                    : (sgn ? {1'b1, 64'h0} : {1'b0, {64{1'b1}}});
        r_d = verbatim ? A[64:0] : ovf ? sat : sgn ? -{1'b0, mag} : {1'b0, mag};
        a_d = !verbatim && (ovf || !(isDBL || isEXT || isSNG));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            res <= '0;
            alt <= 1'b0;
        end else if (clkEn) begin
            res <= r_d;
            alt <= a_d;
        end
    end
endmodule

// File: rtl/fpu_cvt_lane_fifo.sv
// fpu_cvt_lane_fifo: per-lane request FIFO; ready is derived from the
// registered count only, so a full FIFO refuses a push even while popping.
module fpu_cvt_lane_fifo
    import fpu_cvt_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = cvt_req_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     data_o,
    output logic ready_o,
    output logic empty_o
);
    localparam int AW = $clog2(DEPTH);
    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign ready_o = cnt_q < (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign do_push = push_i & ready_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/fpu_cvt_arb.sv
// fpu_cvt_arb: N-lane round-robin convert sequencer feeding a 3-stage FP-to-int
// pipeline. Define FPU_CVT_STATS_EN to add perf_busy/perf_stall counters.
module fpu_cvt_arb
    import fpu_cvt_pkg::*;
#(
    parameter int LANES      = 3,
    parameter int FIFO_DEPTH = 4,
    parameter int TAG_W      = CVT_TAG_W,
    parameter int DATA_W     = CVT_DATA_W,
    localparam int LW        = LANES > 1 ? $clog2(LANES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic [LANES-1:0]        req_valid,
    output logic [LANES-1:0]        req_ready,
    input  logic [3*LANES-1:0]      req_mode,
    input  logic [DATA_W*LANES-1:0] req_data,
    input  logic [TAG_W*LANES-1:0]  req_tag,
    output logic                    res_valid,
    output logic [CVT_RES_W-1:0]    res_data,
    output logic                    res_alt,
    output logic [LW-1:0]           res_lane,
    output logic [TAG_W-1:0]        res_tag
`ifdef FPU_CVT_STATS_EN
    ,
    output logic [31:0]             perf_busy,
    output logic [31:0]             perf_stall
`endif
);
    typedef struct packed {
        cvt_mode_t         mode;
        logic [DATA_W-1:0] data;
        logic [TAG_W-1:0]  tag;
    } req_t;
    req_t                 fifo_in [LANES];
    req_t                 head [LANES];
    logic [LANES-1:0]     ne, pop, rot;
    logic [LW-1:0]        rr_q, rr_d, gnt;
    logic                 gnt_vld;
    int                   off, sum;
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic empty;
        assign fifo_in[i] = '{mode: cvt_mode_t'(req_mode[3*i +: 3]),
                              data: req_data[DATA_W*i +: DATA_W],
                              tag:  req_tag[TAG_W*i +: TAG_W]};
        fpu_cvt_lane_fifo #(.DEPTH(FIFO_DEPTH), .T(req_t)) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (req_valid[i]),
            .data_i  (fifo_in[i]),
            .pop_i   (pop[i]),
            .data_o  (head[i]),
            .ready_o (req_ready[i]),
            .empty_o (empty)
        );
        assign ne[i] = ~empty;
    end
    // Rotate the request vector so bit 0 is rr_q; the lowest set bit wins.
    always_comb begin
        rot     = LANES'({ne, ne} >> rr_q);
        gnt_vld = 1'b0;
        off     = 0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (rot[k]) begin
                gnt_vld = 1'b1;
                off     = k;
            end
        end
        sum  = int'(rr_q) + off;
        gnt  = LW'(sum >= LANES ? sum - LANES : sum);
        rr_d = (gnt_vld && !stall) ? LW'(int'(gnt) + 1 == LANES ? 0 : int'(gnt) + 1) : rr_q;
    end
    assign pop = (gnt_vld && !stall) ? LANES'(1) << gnt : '0;
    req_t                 s0_q;
    logic                 s0_vld_q, s1_vld_q, out_vld_q;
    logic [LW-1:0]        s0_lane_q, s1_lane_q, out_lane_q;
    logic [CVT_OPD_W-1:0] s1_opd_d, s1_opd_q;
    logic                 s1_dbl_d, s1_ext_d, s1_sng_d, s1_32_d, s1_verb_d;
    logic                 s1_dbl_q, s1_ext_q, s1_sng_q, s1_32_q, s1_verb_q;
    logic [TAG_W-1:0]     s1_tag_q, out_tag_q;
    logic                 unused_bits;
    assign unused_bits = ^s0_q.data[DATA_W-17:66];
    always_comb begin
        s1_opd_d  = {ext_mode(s0_q.mode) ? s0_q.data[DATA_W-1 -: 16] : 16'h0, s0_q.data[65:0]};
        s1_dbl_d  = s0_q.mode == CVT_D || s0_q.mode == CVT32_D;
        s1_ext_d  = s0_q.mode == CVT_E;
        s1_verb_d = s0_q.mode == TBL_D;
        s1_32_d   = s0_q.mode == CVT32_S || s0_q.mode == CVT32_D;
        s1_sng_d  = !(s1_dbl_d || s1_ext_d || s1_verb_d);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            s0_vld_q   <= 1'b0;
            s1_vld_q   <= 1'b0;
            out_vld_q  <= 1'b0;
            out_lane_q <= '0;
            out_tag_q  <= '0;
        end else if (!stall) begin
            rr_q       <= rr_d;
            s0_vld_q   <= gnt_vld;
            s1_vld_q   <= s0_vld_q;
            out_vld_q  <= s1_vld_q;
            out_lane_q <= s1_lane_q;
            out_tag_q  <= s1_tag_q;
        end
    end
    always_ff @(posedge clk) begin
        if (!stall) begin
            s0_q      <= head[gnt];
            s0_lane_q <= gnt;
            s1_opd_q  <= s1_opd_d;
            s1_dbl_q  <= s1_dbl_d;
            s1_ext_q  <= s1_ext_d;
            s1_sng_q  <= s1_sng_d;
            s1_32_q   <= s1_32_d;
            s1_verb_q <= s1_verb_d;
            s1_tag_q  <= s0_q.tag;
            s1_lane_q <= s0_lane_q;
        end
    end
    cvt_FP_I_mod u_cvt (
        .clk      (clk),
        .rst      (rst),
        .clkEn    (~stall),
        .A        (s1_opd_q),
        .isDBL    (s1_dbl_q),
        .isEXT    (s1_ext_q),
        .isSNG    (s1_sng_q),
        .is32b    (s1_32_q),
        .verbatim (s1_verb_q),
        .res      (res_data),
        .alt      (res_alt)
    );
    // A held result stays hidden while stalled and shows once stall drops.
    assign res_valid = out_vld_q & ~stall;
    assign res_lane  = out_lane_q;
    assign res_tag   = out_tag_q;
`ifdef FPU_CVT_STATS_EN
    logic [31:0] busy_q, stl_q;
    logic        any_vld;
    assign any_vld = s0_vld_q | s1_vld_q | out_vld_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            stl_q  <= '0;
        end else begin
            busy_q <= busy_q + 32'(any_vld & ~stall);
            stl_q  <= stl_q + 32'(any_vld & stall);
        end
    end
    assign perf_busy  = busy_q;
    assign perf_stall = stl_q;
`endif
endmodule
